// File: rtl/gpu_pkg.sv
// Shared encodings for the core control path: core_state bus values,
// fetcher status and per-lane LSU status.
package gpu_pkg;

    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_FETCH   = 3'b001;
    localparam logic [2:0] CORE_DECODE  = 3'b010;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = CORE_IDLE,
        ST_FETCH   = CORE_FETCH,
        ST_DECODE  = CORE_DECODE,
        ST_REQUEST = CORE_REQUEST,
        ST_WAIT    = CORE_WAIT,
        ST_EXECUTE = CORE_EXECUTE,
        ST_UPDATE  = CORE_UPDATE,
        ST_DONE    = CORE_DONE
    } core_state_e;

    localparam logic [2:0] FETCHER_IDLE     = 3'b000;
    localparam logic [2:0] FETCHER_FETCHING = 3'b001;
    localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

    localparam logic [1:0] LSU_IDLE       = 2'b00;
    localparam logic [1:0] LSU_REQUESTING = 2'b01;
    localparam logic [1:0] LSU_WAITING    = 2'b10;
    localparam logic [1:0] LSU_DONE       = 2'b11;

    // A lane still owes the core a memory response.
    function automatic logic lsu_busy(input logic [1:0] s);
        return (s == LSU_REQUESTING) || (s == LSU_WAITING);
    endfunction

endpackage

// File: rtl/pc_select.sv
// Picks the block PC from the lowest-indexed active lane and reports whether
// any other active lane wants to go somewhere else.
module pc_select #(
    parameter int THREADS   = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic [THREADS-1:0]           mask,
    input  logic [ADDR_BITS*THREADS-1:0] next_pc,
    output logic [ADDR_BITS-1:0]         sel_pc,
    output logic                         any_active,
    output logic                         diverged
);

    logic found;

    always_comb begin
        sel_pc = '0;
        found  = 1'b0;
        for (int i = 0; i < THREADS; i++) begin
            if (mask[i] && !found) begin
                sel_pc = next_pc[i*ADDR_BITS +: ADDR_BITS];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        diverged = 1'b0;
        for (int i = 0; i < THREADS; i++) begin
            if (mask[i] && (next_pc[i*ADDR_BITS +: ADDR_BITS] != sel_pc)) begin
                diverged = 1'b1;
            end
        end
    end

    assign any_active = |mask;

endmodule

// File: rtl/core_scheduler.sv
// Per-core control FSM: walks every instruction through fetch, decode,
// memory request/wait, execute and update for all active lanes of a block.
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [THREADS_PER_BLOCK-1:0]                 thread_enable,
    input  logic [2:0]                                   fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]               lsu_state,
    input  logic                                         decoded_ret,
    input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                                   core_state,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]             current_pc,
    output logic                                         done,
    output logic                                         divergence_error
);

    core_state_e                      state_q, state_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q, pc_d;
    logic                             done_q, done_d;
    logic                             div_q, div_d;
    logic [THREADS_PER_BLOCK-1:0]     mask_q, mask_d;

    logic [PROGRAM_MEM_ADDR_BITS-1:0] sel_pc;
    logic                             any_active;
    logic                             diverged;
    logic                             lanes_busy;

    pc_select #(
        .THREADS   (THREADS_PER_BLOCK),
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS)
    ) u_pc_select (
        .mask       (mask_q),
        .next_pc    (next_pc),
        .sel_pc     (sel_pc),
        .any_active (any_active),
        .diverged   (diverged)
    );

    // Status handshake: the fetcher holds FETCHED and each LSU holds its state
    // until the core moves on; the core only reacts, it never acknowledges.
    always_comb begin
        lanes_busy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (mask_q[i] && lsu_busy(lsu_state[2*i +: 2])) begin
                lanes_busy = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        div_d   = div_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (|thread_enable) begin
                        mask_d  = thread_enable;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (fetcher_state == FETCHER_FETCHED) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE:  state_d = ST_REQUEST;
            ST_REQUEST: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!lanes_busy) begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: state_d = ST_UPDATE;
            ST_UPDATE: begin
                if (decoded_ret) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    // Execution follows the lowest active lane even when lanes split.
                    if (any_active) begin
                        pc_d = sel_pc;
                    end
                    if (diverged) begin
                        div_d = 1'b1;
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_DONE:  done_d = 1'b1;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            div_q   <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            div_q   <= div_d;
            mask_q  <= mask_d;
        end
    end

    assign core_state       = state_q;
    assign current_pc       = pc_q;
    assign done             = done_q;
    assign divergence_error = div_q;

endmodule
